// File: rtl/lane_overlay_writer_pkg.sv
// Shared definitions for the lane overlay writer.
// Holds the default frame geometry, theta/trig formats, the overlay colour,
// the quantised sine quarter-wave table with sin/cos lookup helpers, and the
// controller state type. Ports: none (package).
package lane_overlay_writer_pkg;

  localparam int IMAGE_WIDTH  = 720;
  localparam int IMAGE_HEIGHT = 540;
  localparam int IMAGE_SIZE   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int THETA_BITS   = 9;
  localparam int THETA_COUNT  = 180;
  localparam int TRIG_FRAC    = 10;
  localparam int LINE_TOL     = 1;
  localparam logic [23:0] LANE_COLOR = 24'hFF0000;

  // round(sin(deg) * 2^TRIG_FRAC) for deg = 0..90; the full 0..179 sin/cos
  // tables are folded onto this quarter wave by the helpers below.
  localparam logic signed [15:0] SIN_QUARTER [0:90] = '{
       16'sd0,   16'sd18,  16'sd36,  16'sd54,  16'sd71,  16'sd89,  16'sd107, 16'sd125, 16'sd143, 16'sd160,
     16'sd178,  16'sd195, 16'sd213, 16'sd230, 16'sd248, 16'sd265, 16'sd282, 16'sd299, 16'sd316, 16'sd333,
     16'sd350,  16'sd367, 16'sd384, 16'sd400, 16'sd416, 16'sd433, 16'sd449, 16'sd465, 16'sd481, 16'sd496,
     16'sd512,  16'sd527, 16'sd543, 16'sd558, 16'sd573, 16'sd587, 16'sd602, 16'sd616, 16'sd630, 16'sd644,
     16'sd658,  16'sd672, 16'sd685, 16'sd698, 16'sd711, 16'sd724, 16'sd737, 16'sd749, 16'sd761, 16'sd773,
     16'sd784,  16'sd796, 16'sd807, 16'sd818, 16'sd828, 16'sd839, 16'sd849, 16'sd859, 16'sd868, 16'sd878,
     16'sd887,  16'sd896, 16'sd904, 16'sd912, 16'sd920, 16'sd928, 16'sd935, 16'sd943, 16'sd949, 16'sd956,
     16'sd962,  16'sd968, 16'sd974, 16'sd979, 16'sd984, 16'sd989, 16'sd994, 16'sd998, 16'sd1002, 16'sd1005,
    16'sd1008, 16'sd1011, 16'sd1014, 16'sd1016, 16'sd1018, 16'sd1020, 16'sd1022, 16'sd1023, 16'sd1023, 16'sd1024,
    16'sd1024
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // sin(theta) in Q.TRIG_FRAC; out-of-range theta yields 0 (lane is disabled anyway)
  function automatic logic signed [15:0] sin_quant(input logic [THETA_BITS-1:0] theta);
    logic [6:0] idx;
    if (theta >= THETA_BITS'(THETA_COUNT)) return 16'sd0;
    if (theta <= THETA_BITS'(90)) idx = 7'(theta);
    else idx = 7'(THETA_BITS'(180) - theta);
    return SIN_QUARTER[idx];
  endfunction

  // cos(theta) in Q.TRIG_FRAC; negative in the second quadrant
  function automatic logic signed [15:0] cos_quant(input logic [THETA_BITS-1:0] theta);
    logic [6:0] idx;
    if (theta >= THETA_BITS'(THETA_COUNT)) return 16'sd0;
    if (theta <= THETA_BITS'(90)) begin
      idx = 7'(THETA_BITS'(90) - theta);
      return SIN_QUARTER[idx];
    end
    idx = 7'(theta - THETA_BITS'(90));
    return -SIN_QUARTER[idx];
  endfunction

endpackage

// File: rtl/lane_overlay_writer_hit.sv
// Per-lane hit detector.
// Registers rho_px = x*cos(theta) + y*sin(theta) alongside the pixel stage,
// then compares the integer part against the lane rho within LINE_TOL.
// Ports: clock/reset, load (stage advance), x/y of the pixel being loaded,
// theta/rho/enable of the lane, hit (combinational on the registered product).
module lane_hit_calc
  import lane_overlay_writer_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [THETA_BITS-1:0] theta,
  input  logic signed [15:0]    rho,
  input  logic                  enable,
  output logic                  hit
);

  logic signed [31:0] prod_reg;
  logic signed [31:0] prod_next;
  logic signed [31:0] rho_px;
  logic signed [31:0] diff;

  always_comb begin
    prod_next = $signed(32'(x)) * $signed(32'(cos_quant(theta)))
              + $signed(32'(y)) * $signed(32'(sin_quant(theta)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prod_reg <= '0;
    else if (load) prod_reg <= prod_next;
  end

  always_comb begin
    rho_px = prod_reg >>> TRIG_FRAC;
    diff   = rho_px - $signed(32'(rho));
    hit    = enable && (diff >= -LINE_TOL) && (diff <= LINE_TOL);
  end

endmodule

// File: rtl/lane_overlay_writer.sv
// Lane overlay writer.
// After start (hough done) reads the stored RGB frame from the image BRAM in
// raster order, paints pixels on the left/right lane lines (ROI rows only) in
// LANE_COLOR and writes every pixel to the output FIFO, honouring out_full.
// Ports: clock, reset (async, active-high), start, left/right rho/theta,
// bram_rd_addr/bram_rd_data (1-cycle read latency), out_wr_en/out_full/out_din,
// busy, done.
module lane_overlay_writer
  import lane_overlay_writer_pkg::*;
#(
  parameter int WIDTH  = IMAGE_WIDTH,
  parameter int HEIGHT = IMAGE_HEIGHT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic signed [15:0]                left_rho,
  input  logic signed [15:0]                right_rho,
  input  logic [THETA_BITS-1:0]             left_theta,
  input  logic [THETA_BITS-1:0]             right_theta,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   bram_rd_addr,
  input  logic [23:0]                       bram_rd_data,
  output logic                              out_wr_en,
  input  logic                              out_full,
  output logic [23:0]                       out_din,
  output logic                              busy,
  output logic                              done
);

  localparam int SIZE          = WIDTH * HEIGHT;
  localparam int AW            = $clog2(SIZE);
  localparam int XW            = $clog2(WIDTH);
  localparam int YW            = $clog2(HEIGHT);
  localparam int ROI_START_ROW = HEIGHT / 2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);
  localparam logic [XW-1:0] LAST_X    = XW'(WIDTH - 1);

  state_t state_reg, state_next;

  // addr_reg is the address whose data is on bram_rd_data this cycle
  logic [AW-1:0] addr_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;

  logic          s1_valid_reg;
  logic [23:0]   s1_pixel_reg;
  logic [YW-1:0] s1_y_reg;

  logic          advance;
  logic          last_addr;
  logic          s1_load;
  logic          accept;
  logic [1:0]    hit;
  logic          paint;

  logic signed [15:0]    rho_in   [2];
  logic [THETA_BITS-1:0] theta_in [2];

  assign rho_in[0]   = left_rho;
  assign rho_in[1]   = right_rho;
  assign theta_in[0] = left_theta;
  assign theta_in[1] = right_theta;

  assign accept    = (state_reg == ST_IDLE) && start;
  assign advance   = !(s1_valid_reg && out_full);
  assign last_addr = (addr_reg == LAST_ADDR);
  assign s1_load   = advance && (state_reg == ST_STREAM);

  // A stall re-issues the in-flight address so the BRAM output stays put.
  always_comb begin
    bram_rd_addr = '0;
    if (state_reg == ST_STREAM)
      bram_rd_addr = (advance && !last_addr) ? addr_reg + AW'(1) : addr_reg;
    else if (state_reg == ST_DRAIN)
      bram_rd_addr = addr_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_STREAM;
      ST_STREAM: begin
        busy = 1'b1;
        if (advance && last_addr) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (out_wr_en) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (accept) begin
      addr_reg <= '0;
      x_reg    <= '0;
      y_reg    <= '0;
    end else if (s1_load && !last_addr) begin
      addr_reg <= addr_reg + AW'(1);
      if (x_reg == LAST_X) begin
        x_reg <= '0;
        y_reg <= y_reg + YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

  // Pixel stage: in DRAIN an advance means the last pixel is being written,
  // so valid falls; in STREAM every advance captures a fresh pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_pixel_reg <= '0;
      s1_y_reg     <= '0;
    end else if (advance) begin
      s1_valid_reg <= (state_reg == ST_STREAM);
      if (state_reg == ST_STREAM) begin
        s1_pixel_reg <= bram_rd_data;
        s1_y_reg     <= y_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic signed [15:0]    rho_reg;
      logic [THETA_BITS-1:0] theta_reg;
      logic                  en_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rho_reg   <= '0;
          theta_reg <= '0;
          en_reg    <= 1'b0;
        end else if (accept) begin
          rho_reg   <= rho_in[gi];
          theta_reg <= theta_in[gi];
          en_reg    <= (theta_in[gi] < THETA_BITS'(THETA_COUNT));
        end
      end

      lane_hit_calc #(
        .XW(XW),
        .YW(YW)
      ) u_hit (
        .clock (clock),
        .reset (reset),
        .load  (s1_load),
        .x     (x_reg),
        .y     (y_reg),
        .theta (theta_reg),
        .rho   (rho_reg),
        .enable(en_reg),
        .hit   (hit[gi])
      );
    end
  endgenerate

  assign paint     = (|hit) && (s1_y_reg >= YW'(ROI_START_ROW));
  assign out_wr_en = s1_valid_reg && !out_full;
  assign out_din   = paint ? LANE_COLOR : s1_pixel_reg;

endmodule
